// File: rtl/demux1to4_tdm.sv
// ============================================================================
// Module  : demux1to4_tdm
// Brief   : 1-to-4 demultiplexer, explicit-select or TDM round-robin with sync.
//           Optional DEMUX_FRAME_ERR_EN adds err_clr / sticky frame_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux1to4_tdm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             mode,
   input  logic [1:0]       sel,
   input  logic             sync,
`ifdef DEMUX_FRAME_ERR_EN
   input  logic             err_clr,
   output logic             frame_err,
`endif
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [3:0]       vld,
   output logic             frame_done,
   output logic             locked
);

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   logic [1:0]       r_ch;
   logic [WIDTH-1:0] r_q0;
   logic [WIDTH-1:0] r_q1;
   logic [WIDTH-1:0] r_q2;
   logic [WIDTH-1:0] r_q3;
   logic [3:0]       r_vld;
   logic             r_frame_done;
   logic             r_locked;

   state_t           w_state_nxt;
   logic [1:0]       w_ch_nxt;
   logic             w_wr;
   logic [1:0]       w_lane;
   logic             w_tdm_wr;
   logic             w_misalign;
   logic [3:0]       w_vld_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_wr        = 1'b0;
      w_lane      = 2'd0;
      w_tdm_wr    = 1'b0;
      w_misalign  = 1'b0;
      if (!mode) begin
         // Explicit mode always parks the TDM machine so a new session re-hunts.
         w_state_nxt = ST_HUNT;
         w_ch_nxt    = 2'd0;
         if (din_valid) begin
            w_wr   = 1'b1;
            w_lane = sel;
         end
      end else if (sync) begin
         w_state_nxt = ST_LOCKED;
         w_misalign  = (r_state == ST_LOCKED) && (r_ch != 2'd0);
         if (din_valid) begin
            w_wr     = 1'b1;
            w_lane   = 2'd0;
            w_ch_nxt = 2'd1;
         end else begin
            w_ch_nxt = 2'd0;
         end
      end else if (din_valid && (r_state == ST_LOCKED)) begin
         w_wr     = 1'b1;
         w_lane   = r_ch;
         w_ch_nxt = 2'(r_ch + 2'd1);
      end
      w_tdm_wr  = w_wr & mode;
      w_vld_nxt = w_wr ? (4'b0001 << w_lane) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_HUNT;
         r_ch         <= 2'd0;
         r_q0         <= '0;
         r_q1         <= '0;
         r_q2         <= '0;
         r_q3         <= '0;
         r_vld        <= 4'b0000;
         r_frame_done <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ch         <= w_ch_nxt;
         r_vld        <= w_vld_nxt;
         r_frame_done <= w_tdm_wr && (w_lane == 2'd3);
         r_locked     <= (w_state_nxt == ST_LOCKED);
         if (w_wr) begin
            case (w_lane)
               2'd0:    r_q0 <= din;
               2'd1:    r_q1 <= din;
               2'd2:    r_q2 <= din;
               default: r_q3 <= din;
            endcase
         end
      end
   end

`ifdef DEMUX_FRAME_ERR_EN
   logic r_frame_err;

   // Set has priority over clear when both land in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
      end else if (w_misalign) begin
         r_frame_err <= 1'b1;
      end else if (err_clr) begin
         r_frame_err <= 1'b0;
      end
   end

   assign frame_err = r_frame_err;
`else
   logic w_unused_misalign;
   assign w_unused_misalign = w_misalign;
`endif

   assign q0         = r_q0;
   assign q1         = r_q1;
   assign q2         = r_q2;
   assign q3         = r_q3;
   assign vld        = r_vld;
   assign frame_done = r_frame_done;
   assign locked     = r_locked;

endmodule

`default_nettype wire

// File: doc/demux1to4_tdm.md
DEMUX1TO4_TDM -- requirements
Module: demux1to4_tdm

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data width of the input and each output lane.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-004 din  input  WIDTH  sample to distribute.
REQ-005 din_valid  input  1  din is valid this cycle.
REQ-006 mode  input  1  0 = explicit select, 1 = TDM round-robin.
REQ-007 sel  input  2  destination lane in explicit mode; ignored in TDM mode.
REQ-008 sync  input  1  frame-start marker in TDM mode; ignored in explicit mode.
REQ-009 q0, q1, q2, q3  output  WIDTH each  registered lane data.
REQ-010 vld  output  4  one-cycle pulse per lane; vld[i] marks a new value on q_i.
REQ-011 frame_done  output  1  one-cycle pulse when lane 3 is written in TDM mode.
REQ-012 locked  output  1  high while the TDM FSM is in LOCKED.

Function
REQ-013 Outputs SHALL be registered, with latency 1: a sample accepted at edge N SHALL appear on q_i with vld[i]=1 after edge N.
REQ-014 At most one vld bit SHALL be high in any cycle, and vld SHALL be 0 in any cycle following a cycle with no accepted sample.
REQ-015 Unwritten lanes SHALL hold their previous value.
REQ-016 Explicit mode: when din_valid=1, din SHALL be written to lane sel.
REQ-017 The TDM FSM SHALL have two states, HUNT and LOCKED, and a 2-bit channel counter ch.
REQ-018 HUNT: samples with din_valid=1 and sync=0 SHALL be dropped, with no vld pulse.
REQ-019 HUNT: din_valid=1 with sync=1 SHALL write lane 0, set ch to 1 and move the FSM to LOCKED.
REQ-020 HUNT: sync=1 with din_valid=0 SHALL set ch to 0 and move the FSM to LOCKED.
REQ-021 LOCKED, din_valid=1 and sync=0: the module SHALL write lane ch, then set ch to ch+1 mod 4 (wrap from 3 to 0).
REQ-022 LOCKED, din_valid=1 and sync=1: the module SHALL write lane 0 and set ch to 1, regardless of the current ch (realign).
REQ-023 LOCKED, sync=1 and din_valid=0: the module SHALL set ch to 0.
REQ-024 frame_done SHALL pulse in the same cycle as vld[3] when the write came from TDM mode.
REQ-025 mode=0 SHALL force the FSM to HUNT and ch to 0 at the next edge; a TDM session SHALL always restart with HUNT.
REQ-026 A mode change takes effect on the sample in the same cycle; that sample SHALL be handled under the new mode's rules.

Reset
REQ-027 While rst_n=0, the outputs SHALL be q0..q3=0, vld=0, frame_done=0, locked=0, with FSM=HUNT and ch=0, regardless of clk.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, and no vld pulse SHALL occur in the first edge after reset is released unless a sample is accepted at that edge.

Configuration
REQ-029 When the macro DEMUX_FRAME_ERR_EN is defined, the module SHALL add input err_clr (1 bit) and output frame_err (1 bit, reset 0).
REQ-030 With DEMUX_FRAME_ERR_EN defined, a sync in LOCKED with ch!=0 SHALL set frame_err sticky, and err_clr=1 SHALL clear it; if both events occur in the same cycle, the set SHALL win.
REQ-031 When DEMUX_FRAME_ERR_EN is undefined, these ports SHALL be absent and misaligned syncs SHALL realign silently per REQ-022.

Verification
REQ-032 Explicit mode: mode=0, din=8'hA5, sel=2, din_valid=1 for one cycle -> q2=8'hA5 and vld=4'b0100 for exactly one cycle; q0, q1 and q3 unchanged.
REQ-033 TDM lock: mode=1, send 11,22 without sync, then 33(sync),44,55,66 -> 11 and 22 dropped; q0..q3=33,44,55,66; vld walks 0001,0010,0100,1000; frame_done coincides with vld[3]; locked=1 from the sync edge.
REQ-034 TDM wrap with gaps: after lock, send 8 samples with din_valid deasserted every other cycle -> lanes fill 0,1,2,3,0,1,2,3; frame_done pulses twice; no vld in idle cycles.
REQ-035 Misalignment: locked, write lanes 0 and 1, then sync with din=8'h77 -> q0=8'h77 and ch=1; frame_err=1 when the macro is on, then err_clr -> 0; with the macro off, only the realign occurs.
REQ-036 Reset and mode: assert rst_n=0 mid-frame -> all outputs 0 immediately; in LOCKED, switch mode to 0 for one cycle -> locked=0, and later samples are dropped until the next sync.
